// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, default sizing and
// the field layout of a 16-bit instruction word.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      WRITE,
      FINISH
   } pl_state_e;

   localparam int unsigned PL_DEPTH    = 16;
   localparam logic [15:0] PL_END_WORD = 16'hFFFF;

   // Instruction word layout: opcode | ip1 | ip2 | op, four bits each
   localparam int unsigned FIELD_W    = 4;
   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned IP1_LSB    = 8;
   localparam int unsigned IP2_LSB    = 4;
   localparam int unsigned OP_LSB     = 0;

endpackage

// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles high/low byte pairs into 16-bit words and
// writes them to program memory from address 0, holding the CU until the load ends.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned DEPTH    = PL_DEPTH,
   parameter logic [15:0] END_WORD = PL_END_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        pm_we,
   output logic [7:0]  pm_addr,
   output logic [15:0] pm_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        overflow,
   output logic [7:0]  word_count
);

   localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

   pl_state_e   state_q, state_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  word_count_q, word_count_d;
   logic        overflow_q, overflow_d;
   logic        byte_ready_q, byte_ready_d;
   logic        cpu_hold_q, cpu_hold_d;
   logic        done_q, done_d;
   logic        pm_we_q, pm_we_d;
   logic [7:0]  pm_addr_q, pm_addr_d;
   logic [15:0] pm_wdata_q, pm_wdata_d;
   logic        accept;
   logic [15:0] word;

   assign accept = byte_valid & byte_ready_q;
   assign word   = {hi_q, byte_in};

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;
      pm_we_d      = 1'b0;
      pm_addr_d    = pm_addr_q;
      pm_wdata_d   = pm_wdata_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = HI;
               addr_d       = '0;
               word_count_d = '0;
               overflow_d   = 1'b0;
            end
         end
         HI: begin
            if (accept) begin
               hi_d    = byte_in;
               state_d = LO;
            end
         end
         LO: begin
            if (accept) begin
               state_d = WRITE;
               // The terminator only steers WRITE to FINISH; it never reaches memory
               if (word != END_WORD) begin
                  pm_we_d    = 1'b1;
                  pm_addr_d  = addr_q;
                  pm_wdata_d = word;
               end
            end
         end
         WRITE: begin
            if (pm_we_q) begin
               addr_d       = addr_q + 8'd1;
               word_count_d = word_count_q + 8'd1;
               // 9-bit compare so DEPTH=256 is reached even though word_count wraps to 0
               if (({1'b0, word_count_q} + 9'd1) == DEPTH_9) begin
                  overflow_d = 1'b1;
                  state_d    = FINISH;
               end else begin
                  state_d = HI;
               end
            end else begin
               state_d = FINISH;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered copies decoded from the next state
      byte_ready_d = (state_d == HI) || (state_d == LO);
      cpu_hold_d   = (state_d == HI) || (state_d == LO) || (state_d == WRITE);
      done_d       = (state_d == FINISH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         hi_q         <= '0;
         addr_q       <= '0;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
         byte_ready_q <= 1'b0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
         pm_we_q      <= 1'b0;
         pm_addr_q    <= '0;
         pm_wdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
         byte_ready_q <= byte_ready_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         pm_we_q      <= pm_we_d;
         pm_addr_q    <= pm_addr_d;
         pm_wdata_q   <= pm_wdata_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign word_count = word_count_q;
   assign pm_we      = pm_we_q;
   assign pm_addr    = pm_addr_q;
   assign pm_wdata   = pm_wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives byte streams and checks the memory
// write log, handshake, status flags and reset behaviour against fixed values.
`timescale 1ns/1ps
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        pm_we;
   logic [7:0]  pm_addr;
   logic [15:0] pm_wdata;
   logic        cpu_hold;
   logic        done;
   logic        overflow;
   logic [7:0]  word_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mem    [0:255];
   int          wr_cnt [0:255];
   int          total_wr = 0;
   int          done_cnt = 0;

   prog_loader #(
      .DEPTH    (16),
      .END_WORD (16'hFFFF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .pm_we      (pm_we),
      .pm_addr    (pm_addr),
      .pm_wdata   (pm_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Program memory model: pm_we is high for a full cycle, so one sample per write
   always @(negedge clk) begin
      if (pm_we) begin
         mem[pm_addr]    = pm_wdata;
         wr_cnt[pm_addr] = wr_cnt[pm_addr] + 1;
         total_wr        = total_wr + 1;
      end
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      for (int i = 0; i < 256; i++) begin
         mem[i]    = '0;
         wr_cnt[i] = 0;
      end
      total_wr = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      byte_valid = 1'b0;
      repeat (gap) tick();
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check_eq("byte_ready_timeout", 32'(byte_ready), 32'd1);
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check_eq({tag, "_done_lat"}, 32'(n), 32'(exp_lat));
      check_eq({tag, "_hold_at_done"}, 32'(cpu_hold), 32'd0);
      tick();
      check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ok;
      int dc;
      logic [15:0] w;

      clear_log();
      rst        = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = '0;
      #1 rst = 1'b1;
      #2;
      check_eq("rst_ctrl", 32'({byte_ready, pm_we, cpu_hold, done, overflow}), 32'd0);
      check_eq("rst_addr_data", 32'({pm_addr, pm_wdata}), 32'd0);
      check_eq("rst_word_count", 32'(word_count), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Bytes offered while idle must be ignored and nothing must start
      byte_in    = 8'h12;
      byte_valid = 1'b1;
      repeat (4) tick();
      check_eq("idle_ready", 32'({byte_ready, cpu_hold}), 32'd0);
      check_eq("idle_no_write", 32'(total_wr), 32'd0);
      byte_valid = 1'b0;

      // Single word then terminator, valid held high
      clear_log();
      pulse_start();
      check_eq("t1_hi_state", 32'({byte_ready, cpu_hold}), 32'b11);
      send_byte(8'h85, 0);
      send_byte(8'h62, 0);
      check_eq("t1_write_strobe", 32'({pm_we, byte_ready}), 32'b10);
      check_eq("t1_write_addr", 32'(pm_addr), 32'd0);
      check_eq("t1_write_data", 32'(pm_wdata), 32'h8562);
      tick();
      check_eq("t1_we_drop", 32'(pm_we), 32'd0);
      check_eq("t1_data_hold", 32'(pm_wdata), 32'h8562);
      check_eq("t1_count_inc", 32'(word_count), 32'd1);
      send_byte(8'hFF, 0);
      send_byte(8'hFF, 0);
      check_eq("t1_no_term_write", 32'(pm_we), 32'd0);
      wait_done("t1", 1);
      check_eq("t1_word_count", 32'(word_count), 32'd1);
      check_eq("t1_overflow", 32'(overflow), 32'd0);
      check_eq("t1_total_wr", 32'(total_wr), 32'd1);
      check_eq("t1_mem0", 32'(mem[0]), 32'h8562);

      // Three words with random gaps; start pulsed during WRITE and during HI
      clear_log();
      pulse_start();
      send_byte(8'h75, $urandom_range(0, 3));
      send_byte(8'h62, $urandom_range(0, 3));
      send_byte(8'h66, $urandom_range(0, 3));
      send_byte(8'h04, $urandom_range(0, 3));
      pulse_start();
      pulse_start();
      send_byte(8'h75, $urandom_range(0, 3));
      send_byte(8'h02, $urandom_range(0, 3));
      send_byte(8'hFF, $urandom_range(0, 3));
      send_byte(8'hFF, $urandom_range(0, 3));
      wait_done("t2", 1);
      check_eq("t2_mem0", 32'(mem[0]), 32'h7562);
      check_eq("t2_mem1", 32'(mem[1]), 32'h6604);
      check_eq("t2_mem2", 32'(mem[2]), 32'h7502);
      check_eq("t2_once", 32'({wr_cnt[0] == 1, wr_cnt[1] == 1, wr_cnt[2] == 1}), 32'b111);
      check_eq("t2_total_wr", 32'(total_wr), 32'd3);
      check_eq("t2_word_count", 32'(word_count), 32'd3);
      check_eq("t2_overflow", 32'(overflow), 32'd0);

      // Fill all 16 words without a terminator
      clear_log();
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         w = {4'h4, 4'(i), 8'(8'h20 + i)};
         send_byte(w[15:8], i % 2);
         send_byte(w[7:0], 0);
      end
      wait_done("t3", 1);
      ok = 0;
      for (int i = 0; i < 16; i++) begin
         w = {4'h4, 4'(i), 8'(8'h20 + i)};
         if (wr_cnt[i] == 1 && mem[i] == w) ok++;
      end
      check_eq("t3_all_words", 32'(ok), 32'd16);
      check_eq("t3_total_wr", 32'(total_wr), 32'd16);
      check_eq("t3_overflow", 32'(overflow), 32'd1);
      check_eq("t3_word_count", 32'(word_count), 32'd16);
      check_eq("t3_last_addr", 32'(pm_addr), 32'd15);
      byte_in    = 8'h50;
      byte_valid = 1'b1;
      repeat (5) tick();
      check_eq("t3_ready_after", 32'({byte_ready, cpu_hold}), 32'd0);
      check_eq("t3_no_17th", 32'(total_wr + wr_cnt[16]), 32'd16);
      byte_valid = 1'b0;

      // Reset after the high byte of word 2
      clear_log();
      dc = done_cnt;
      pulse_start();
      send_byte(8'hA1, 0);
      send_byte(8'h11, 0);
      send_byte(8'hA2, 0);
      send_byte(8'h22, 0);
      send_byte(8'hA3, 0);
      rst = 1'b1;
      #1;
      check_eq("t4_rst_ctrl", 32'({byte_ready, pm_we, cpu_hold, done, overflow}), 32'd0);
      check_eq("t4_rst_addr_data", 32'({pm_addr, pm_wdata}), 32'd0);
      check_eq("t4_rst_count", 32'(word_count), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      check_eq("t4_stay_idle", 32'({byte_ready, cpu_hold}), 32'd0);
      check_eq("t4_no_done", 32'(done_cnt), 32'(dc));
      check_eq("t4_kept_words", 32'({mem[0], mem[1]}), 32'hA111A222);
      check_eq("t4_total_wr", 32'(total_wr), 32'd2);
      pulse_start();
      send_byte(8'hB1, 0);
      send_byte(8'h23, 0);
      send_byte(8'hFF, 0);
      send_byte(8'hFF, 0);
      wait_done("t4", 1);
      check_eq("t4_reload_addr0", 32'(mem[0]), 32'hB123);
      check_eq("t4_reload_cnt", 32'(wr_cnt[0]), 32'd2);
      check_eq("t4_reload_wc", 32'(word_count), 32'd1);

      // Immediate terminator
      clear_log();
      pulse_start();
      check_eq("t5_hold_start", 32'(cpu_hold), 32'd1);
      send_byte(8'hFF, 0);
      send_byte(8'hFF, 0);
      check_eq("t5_hold_write", 32'(cpu_hold), 32'd1);
      wait_done("t5", 1);
      check_eq("t5_no_write", 32'(total_wr), 32'd0);
      check_eq("t5_word_count", 32'(word_count), 32'd0);
      check_eq("t5_overflow", 32'(overflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of program-memory words; legal range 2..256.
REQ-002 Parameter END_WORD, default 16'hFFFF, terminator instruction; ends a load and is never written.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock shared with the CU.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a load at address 0.
REQ-007 byte_in  input  8  instruction byte; high byte (opcode,ip1) first, then low byte (ip2,op).
REQ-008 byte_valid  input  1  byte_in is valid this cycle.
REQ-009 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-010 pm_we  output  1  program-memory write strobe, one cycle per word.
REQ-011 pm_addr  output  8  program-memory write address.
REQ-012 pm_wdata  output  16  assembled instruction word.
REQ-013 cpu_hold  output  1  holds the CU (p_c frozen, no execution) while a load is in progress.
REQ-014 done  output  1  one-cycle pulse when a load completes.
REQ-015 overflow  output  1  sticky flag: DEPTH words written before END_WORD was seen.
REQ-016 word_count  output  8  number of words written in the current or most recent load.

Function
REQ-017 States: IDLE, HI, LO, WRITE, FINISH; encoding is free.
REQ-018 IDLE: byte_ready=0 and cpu_hold=0; start -> HI, clears word_count, overflow and the address counter, sets cpu_hold.
REQ-019 HI: byte_ready=1; a byte is accepted only when byte_valid and byte_ready are both 1 on a rising edge; an accepted byte is latched as [15:8] -> LO.
REQ-020 LO: byte_ready=1; an accepted byte is latched as [7:0] -> WRITE.
REQ-021 WRITE: byte_ready=0; if the word equals END_WORD -> FINISH with no write; otherwise pm_we=1 for exactly one cycle with pm_addr=current address and pm_wdata=the word; the address and word_count then increment.
REQ-022 After a write, if word_count reaches DEPTH -> FINISH with overflow=1; otherwise -> HI.
REQ-023 FINISH: done=1 for one cycle; cpu_hold=0 from the same cycle onward -> IDLE.
REQ-024 Latency: from acceptance of the low byte, pm_we is asserted exactly one cycle later.
REQ-025 byte_valid without byte_ready (IDLE, WRITE, FINISH): the byte is ignored and not consumed.
REQ-026 start while not IDLE is ignored; the load continues unaffected.
REQ-027 The address never wraps: pm_addr stays in 0..DEPTH-1, and a DEPTH+1-th word is never written.
REQ-028 pm_addr and pm_wdata hold their last values when pm_we=0; the memory samples them only when pm_we=1.
REQ-029 word_count width is 8; DEPTH=256 saturates via overflow, and word_count reads 0 after 256 writes (modulo 256).

Reset
REQ-030 rst asserted at any time: state=IDLE, byte_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=0, done=0, overflow=0, word_count=0, asynchronously.
REQ-031 A reset in mid-load abandons the partial word; words already written stay in memory, and no done pulse is generated.
REQ-032 After rst is released, the first state change occurs on the first rising clk edge that has start=1.

Structure
REQ-033 A shared package holds the state enumeration, the default END_WORD and DEPTH constants, and the instruction field offsets (opcode [15:12], ip1 [11:8], ip2 [7:4], op [3:0]).
REQ-034 The block has no sub-module; the state machine, byte assembler and address counter are in one module.
REQ-035 The program-memory write port (pm_we/pm_addr/pm_wdata) and the cpu_hold gating of p_c update are added in the CU; they are outside this block.

Verification
REQ-036 start, bytes 85 62 FF FF with byte_valid held 1 -> one write addr 0 data 8562, done one cycle after FF FF, word_count=1, overflow=0.
REQ-037 Bytes 75 62 66 04 75 02 FF FF with random byte_valid gaps -> writes 0:7562, 1:6604, 2:7502, each exactly once, done, word_count=3.
REQ-038 DEPTH=16, 17 non-terminator words -> 16 writes (addr 0..15), overflow=1, done, 17th word never written, byte_ready=0 afterward.
REQ-039 rst asserted after the high byte of word 2 -> all outputs 0 immediately, no done, words 0..1 retained; a new start reloads from addr 0.
REQ-040 start pulsed during HI/WRITE, and byte_valid in IDLE -> no state disturbance, no extra write, no byte consumed.
REQ-041 First bytes FF FF -> no pm_we, done one cycle later, word_count=0, cpu_hold high only during the load.
